// File: rtl/ce_sched_pkg.sv
// Shared types and defaults for the clock-enable scheduler.
// Holds the FSM state encoding and counter width helper.
package ce_sched_pkg;

  localparam int DEF_PPU_DIV   = 4;
  localparam int DEF_CPU_RATIO = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    STEP   = 2'd3
  } state_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Reloadable down-counter with advance input and zero flag.
// load has priority and forces an arbitrary start value.
module ce_divider #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         advance,
  input  logic [W-1:0] reload_val,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  // Count down on advance, wrapping to reload_val after zero.
  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (advance) begin
      count <= zero ? reload_val : count - 1'b1;
    end
  end

endmodule

// File: rtl/ce_scheduler.sv
// Generates PPU/CPU/APU clock enables from ref_clk with
// pause and single-step control at CPU-cycle boundaries.
module ce_scheduler
  import ce_sched_pkg::*;
#(
  parameter int PPU_DIV   = DEF_PPU_DIV,
  parameter int CPU_RATIO = DEF_CPU_RATIO
) (
  input  logic ref_clk,
  input  logic reset,
  input  logic enable,
  input  logic pause_req,
  input  logic step_req,
  output logic ppu_ce,
  output logic cpu_ce,
  output logic apu_ce,
  output logic step_ack,
  output logic paused
);

  localparam int DW = cw(PPU_DIV);
  localparam int SW = cw(CPU_RATIO);
  localparam logic [DW-1:0] DIV_MAX = DW'(PPU_DIV - 1);
  localparam logic [SW-1:0] SUB_MAX = SW'(CPU_RATIO - 1);

  state_t        state;
  logic          toggle;
  logic [DW-1:0] div_cnt;
  logic          div_zero;
  logic [SW-1:0] sub_cnt;
  logic          sub_zero;
  logic          active;
  logic          div_tick;
  logic          cpu_tick;
  logic          clr;

  assign active   = (state == RUN) || (state == STEP);
  assign div_tick = active && div_zero;
  assign cpu_tick = div_tick && sub_zero;
  assign clr      = reset || !enable;

  ce_divider #(.W(DW)) u_div (
    .clk        (ref_clk),
    .load       (clr),
    .load_val   (DIV_MAX),
    .advance    (active),
    .reload_val (DIV_MAX),
    .count      (div_cnt),
    .zero       (div_zero)
  );

  ce_divider #(.W(SW)) u_sub (
    .clk        (ref_clk),
    .load       (clr),
    .load_val   ('0),
    .advance    (div_tick),
    .reload_val (SUB_MAX),
    .count      (sub_cnt),
    .zero       (sub_zero)
  );

  // State machine with registered enables and status.
  always_ff @(posedge ref_clk) begin
    if (clr) begin
      state    <= IDLE;
      toggle   <= 1'b0;
      ppu_ce   <= 1'b0;
      cpu_ce   <= 1'b0;
      apu_ce   <= 1'b0;
      step_ack <= 1'b0;
      paused   <= 1'b0;
    end else begin
      ppu_ce   <= div_tick;
      cpu_ce   <= cpu_tick;
      apu_ce   <= cpu_tick && !toggle;
      step_ack <= 1'b0;
      paused   <= 1'b0;
      if (cpu_tick) toggle <= ~toggle;
      unique case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (pause_req && cpu_tick) state <= PAUSED;
        end
        PAUSED: begin
          if (!pause_req) begin
            state <= RUN;
          end else if (step_req) begin
            state <= STEP;
          end else begin
            paused <= 1'b1;
          end
        end
        STEP: begin
          if (cpu_tick) begin
            state    <= PAUSED;
            step_ack <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ce_scheduler.md
CE_SCHEDULER -- requirements
Module: ce_scheduler

Interface
REQ-001 SHALL have parameter PPU_DIV, default 4, meaning ref_clk edges per ppu_ce (legal range 2..64).
REQ-002 SHALL have parameter CPU_RATIO, default 3, meaning ppu_ce pulses per cpu_ce (legal range 1..16).
REQ-003 SHALL have port ref_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  level; high = scheduler runs, low = forced IDLE.
REQ-006 SHALL have port pause_req  input  1  level; request to stop at the next cpu_ce boundary.
REQ-007 SHALL have port step_req  input  1  single-cycle pulse; advance one CPU cycle while paused.
REQ-008 SHALL have port ppu_ce  output  1  registered one-cycle clock enable for the PPU.
REQ-009 SHALL have port cpu_ce  output  1  registered one-cycle clock enable for the CPU.
REQ-010 SHALL have port apu_ce  output  1  registered one-cycle clock enable for the APU (every second cpu_ce).
REQ-011 SHALL have port step_ack  output  1  registered pulse; the step's cpu_ce was issued.
REQ-012 SHALL have port paused  output  1  registered; high only in state PAUSED.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSED, STEP.
REQ-014 Divider counter SHALL count PPU_DIV-1 down to 0, reloading PPU_DIV-1 at 0; it advances only in RUN/STEP. div_tick = (count==0) in RUN/STEP.
REQ-015 ppu_ce SHALL be registered from div_tick, so it is high in the cycle after the PPU_DIV-th advancing edge, then every PPU_DIV edges.
REQ-016 Sub-counter SHALL reset to 0 and, on each div_tick, load CPU_RATIO-1 if 0, else decrement. cpu_tick = div_tick and sub==0; cpu_ce registered from cpu_tick, coincident with ppu_ce.
REQ-017 A toggle SHALL start at 0 and flip on each cpu_tick. apu_ce registered from cpu_tick and toggle==0.
REQ-018 IDLE->RUN SHALL occur on the first edge with enable high.
REQ-019 RUN->PAUSED SHALL occur on an edge where pause_req is high and cpu_tick is true; that edge's ce pulses are still issued.
REQ-020 In PAUSED, counters SHALL hold and all ce outputs SHALL be low.
REQ-021 PAUSED->RUN SHALL occur on an edge where pause_req is low; step_req is then ignored.
REQ-022 PAUSED->STEP SHALL occur on an edge where pause_req and step_req are both high; step_req in any other state is ignored.
REQ-023 STEP->PAUSED SHALL occur on the cpu_tick edge; step_ack is registered high coincident with that cpu_ce.
REQ-024 enable low SHALL force IDLE from any state on the next edge, with priority over all other inputs. It reloads the divider, zeroes the sub-counter and toggle, and drives all outputs low.
REQ-025 After PAUSED, the first cpu_ce SHALL come exactly PPU_DIV*CPU_RATIO advancing edges later, so the phase is preserved.

Reset
REQ-026 reset SHALL override enable. It sets state IDLE, divider PPU_DIV-1, sub-counter 0, toggle 0, and ppu_ce/cpu_ce/apu_ce/step_ack/paused all 0.
REQ-027 Reset asserted mid-STEP SHALL drop the step without step_ack.

Structure
REQ-028 Package ce_sched_pkg SHALL hold the state enum and the default PPU_DIV/CPU_RATIO constants.
REQ-029 A sub-module ce_divider SHALL implement a reloadable down-counter with advance input and zero flag. It is instantiated twice, for the divider and the sub-counter, each with width $clog2 of its parameter (minimum 1).

Verification
REQ-030 Defaults, reset released, enable=1 from edge 0 -> ppu_ce after edges 4,8,12,...; cpu_ce after edges 4,16,28; apu_ce after edges 4,28,52.
REQ-031 pause_req raised at edge 10 -> cpu_ce and final ppu_ce after edge 16; paused=1 from edge 17; no ce pulses while held.
REQ-032 Paused, step_req pulse sampled at edge s -> ppu_ce after s+4 and s+8; cpu_ce, ppu_ce and step_ack after s+12; paused back to 1 after s+13.
REQ-033 Paused, pause_req and step_req dropped/pulsed on the same edge -> RUN entered, no step_ack, next cpu_ce 12 edges later.
REQ-034 enable dropped mid-RUN, reasserted 5 cycles later -> outputs 0 meanwhile; pattern restarts exactly as in REQ-030, with apu_ce on the first cpu_ce.
REQ-035 reset pulsed during STEP -> all outputs 0, no step_ack; state IDLE, or RUN on the following edge if enable is high.
